fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Sequences an in-place radix-2 DIT FFT over N=2**N_LOG2 points held in a dual-port sample RAM.
//  Per stage: issues one butterfly per cycle (operand addresses A/B plus twiddle ROM index).
//  Delays the same addresses by the butterfly pipeline latency to drive RAM write-back.
//  Drains the pipeline between stages so a stage never reads data before the previous stage wrote it.
//  tw_addr is the final cos/sin LUT index; the twiddle ROM is instantiated with no internal stage scaling (stage_no=0).
// PARAMETERS
//  N_LOG2    10   log2 of FFT length; N=2**N_LOG2; butterflies per stage = N/2
//  ROM_LEN   512  twiddle LUT depth; must be >= N/2 (elaboration-time check, $error otherwise)
//  PIPE_LAT  4    cycles from rd_en to matching wr_en (RAM read + butterfly); >= 1
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        request a full transform; sampled only in IDLE
//  stall      in   1        hold issue (RAM port contention); honoured only in RUN
//  busy       out  1        high from cycle after start accepted until done pulse (inclusive)
//  done       out  1        one-cycle pulse after final stage drained
//  stage      out  N_LOG2   current stage index s, 0..N_LOG2-1
//  rd_en      out  1        butterfly issued this cycle
//  rd_addr_a  out  N_LOG2   top operand address
//  rd_addr_b  out  N_LOG2   bottom operand address = rd_addr_a + 2**s
//  tw_addr    out  16       twiddle index, zero-extended; valid when rd_en
//  wr_en      out  1        rd_en delayed PIPE_LAT cycles
//  wr_addr_a  out  N_LOG2   rd_addr_a delayed PIPE_LAT cycles
//  wr_addr_b  out  N_LOG2   rd_addr_b delayed PIPE_LAT cycles
// BEHAVIOUR
//  - Reset: state=IDLE; cnt, stage, drain counter = 0; write-delay pipe flushed.
//    All outputs 0 from the cycle after rst is sampled, including a reset taken mid-transform.
//  - FSM: IDLE -> RUN on start; RUN -> DRAIN after issuing cnt=N/2-1.
//    DRAIN -> RUN (stage+1, cnt=0) after PIPE_LAT cycles, unless stage=N_LOG2-1.
//    In that case DRAIN -> DONE after PIPE_LAT cycles. DONE -> IDLE after 1 cycle.
//  - busy = (state != IDLE). done = (state == DONE).
//  - rd_en = (state==RUN) && !stall. cnt advances only when rd_en=1; addresses hold under stall.
//  - First rd_en is the cycle after start is sampled.
//  - Address generation for counter cnt (N_LOG2-1 bits), stage s:
//    j = cnt & (2**s-1);
//    rd_addr_a = ((cnt >> s) << (s+1)) | j   (zero inserted at bit s);
//    tw_addr   = j << (N_LOG2-1-s).
//    All outputs are combinational from registered state; no arithmetic overflow.
//  - Write side: a PIPE_LAT-deep shift register of {rd_en, rd_addr_a, rd_addr_b}.
//    It always shifts, independent of stall and state.
//  - Drain: last issue at cycle t gives last wr_en at t+PIPE_LAT; DRAIN occupies t+1..t+PIPE_LAT.
//    The next stage's first read is at t+PIPE_LAT+1, so RAM write-then-read ordering is guaranteed.
//  - start while busy: ignored, no queuing. start in the DONE cycle: ignored.
//  - start and rst in the same cycle: rst wins.
//  - stall in DRAIN/DONE/IDLE: no effect.
//  - Stage wrap: stage never exceeds N_LOG2-1; cnt wraps to 0 at each stage boundary.
// TESTING
//  1. N_LOG2=3, PIPE_LAT=2, stall=0, start@cyc0 ->
//     stage0 A=0,2,4,6 B=1,3,5,7 tw=0,0,0,0 at cyc1-4; drain cyc5-6.
//  2. Same run ->
//     stage1 A=0,1,4,5 B=2,3,6,7 tw=0,2,0,2 at cyc7-10;
//     stage2 A=0,1,2,3 B=4,5,6,7 tw=0,1,2,3 at cyc13-16; done=1 only at cyc19.
//  3. Same run -> wr_en/wr_addr equal rd_* shifted by exactly 2 cycles;
//     no rd_en in any cycle with pending wr_en from the previous stage.
//  4. stall=1 at cyc2-4 of test 1 ->
//     rd_en=0 with A=2 held for 3 cycles; sequence resumes unchanged; done delayed 3 cycles to cyc22.
//  5. start re-asserted at cyc8 and cyc19 -> ignored; busy falls at cyc20; start@cyc20 begins a new run.
//  6. rst at cyc9 mid-run ->
//     cyc10: busy=0, rd_en=wr_en=0, stage=0, A=0; no spurious wr_en afterward;
//     start@cyc12 reproduces test 1 offset by 12.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Address/control sequencer for an in-place radix-2 DIT FFT.
//               Issues one butterfly per cycle per stage (operand addresses
//               plus twiddle index), delays them by the butterfly latency for
//               RAM write-back, and drains the pipe between stages.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter int N_LOG2   = 10,
    parameter int ROM_LEN  = 512,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [15:0]       tw_addr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    // The twiddle LUT must cover every index j << (N_LOG2-1-s) < N/2.
    if (ROM_LEN < (2 ** (N_LOG2 - 1))) begin : g_rom_len_check
        $error("fft_stage_sequencer: ROM_LEN must be >= N/2");
    end
    if (PIPE_LAT < 1) begin : g_pipe_lat_check
        $error("fft_stage_sequencer: PIPE_LAT must be >= 1");
    end

    localparam int                c_DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(PIPE_LAT - 1);
    localparam logic [N_LOG2-2:0] c_CNT_LAST   = {(N_LOG2-1){1'b1}};
    localparam logic [N_LOG2-1:0] c_STAGE_LAST = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] c_ONE        = N_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [N_LOG2-2:0]     r_cnt_q,   w_cnt_d;
    logic [N_LOG2-1:0]     r_stage_q, w_stage_d;
    logic [c_DRAIN_W-1:0]  r_drain_q, w_drain_d;

    logic [PIPE_LAT-1:0]              r_pipe_en_q, w_pipe_en_d;
    logic [PIPE_LAT-1:0][N_LOG2-1:0]  r_pipe_a_q,  w_pipe_a_d;
    logic [PIPE_LAT-1:0][N_LOG2-1:0]  r_pipe_b_q,  w_pipe_b_d;

    logic [N_LOG2-1:0] w_cnt_ext;
    logic [N_LOG2-1:0] w_j;
    logic [N_LOG2-1:0] w_a;
    logic [N_LOG2-1:0] w_b;
    logic [15:0]       w_tw;
    logic              w_issue;

    // Butterfly addressing: insert a zero at bit s of the counter for A,
    // B sits 2**s above A, twiddle is the in-group offset scaled to the LUT.
    always_comb begin
        w_cnt_ext = {1'b0, r_cnt_q};
        w_j       = w_cnt_ext & ((c_ONE << r_stage_q) - c_ONE);
        w_a       = ((w_cnt_ext >> r_stage_q) << (r_stage_q + c_ONE)) | w_j;
        w_b       = w_a + (c_ONE << r_stage_q);
        w_tw      = 16'(w_j) << (c_STAGE_LAST - r_stage_q);
        w_issue   = (r_state_q == S_RUN) && !stall;
    end

    // Next-state logic: issue N/2 butterflies, drain PIPE_LAT cycles, repeat per stage.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_stage_d = r_stage_q;
        w_drain_d = r_drain_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_RUN;
                    w_cnt_d   = '0;
                    w_stage_d = '0;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    if (r_cnt_q == c_CNT_LAST) begin
                        w_cnt_d   = '0;
                        w_drain_d = '0;
                        w_state_d = S_DRAIN;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_q == c_DRAIN_LAST) begin
                    w_drain_d = '0;
                    if (r_stage_q == c_STAGE_LAST) begin
                        w_state_d = S_DONE;
                    end else begin
                        w_stage_d = r_stage_q + c_ONE;
                        w_state_d = S_RUN;
                    end
                end else begin
                    w_drain_d = r_drain_q + 1'b1;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                w_stage_d = '0;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Write-back delay line; shifts every cycle regardless of stall or state.
    always_comb begin
        w_pipe_en_d    = '0;
        w_pipe_a_d     = '0;
        w_pipe_b_d     = '0;
        w_pipe_en_d[0] = rd_en;
        w_pipe_a_d[0]  = rd_addr_a;
        w_pipe_b_d[0]  = rd_addr_b;
        for (int i = 1; i < PIPE_LAT; i++) begin
            w_pipe_en_d[i] = r_pipe_en_q[i-1];
            w_pipe_a_d[i]  = r_pipe_a_q[i-1];
            w_pipe_b_d[i]  = r_pipe_b_q[i-1];
        end
    end

    // State, counters and delay line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_cnt_q     <= '0;
            r_stage_q   <= '0;
            r_drain_q   <= '0;
            r_pipe_en_q <= '0;
            r_pipe_a_q  <= '0;
            r_pipe_b_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_stage_q   <= w_stage_d;
            r_drain_q   <= w_drain_d;
            r_pipe_en_q <= w_pipe_en_d;
            r_pipe_a_q  <= w_pipe_a_d;
            r_pipe_b_q  <= w_pipe_b_d;
        end
    end

    // Outputs; read-side addresses forced to zero while idle so reset leaves everything at 0.
    always_comb begin
        busy      = (r_state_q != S_IDLE);
        done      = (r_state_q == S_DONE);
        stage     = r_stage_q;
        rd_en     = w_issue;
        rd_addr_a = (r_state_q == S_IDLE) ? '0 : w_a;
        rd_addr_b = (r_state_q == S_IDLE) ? '0 : w_b;
        tw_addr   = (r_state_q == S_IDLE) ? '0 : w_tw;
        wr_en     = r_pipe_en_q[PIPE_LAT-1];
        wr_addr_a = r_pipe_a_q[PIPE_LAT-1];
        wr_addr_b = r_pipe_b_q[PIPE_LAT-1];
    end

endmodule
`default_nettype wire
